md5_step_stage: RTL and testbench
=================================

Name: md5_step_stage

Overview:
- One registered MD5 step (one of 64); instances chain back-to-back to form a fully unrolled, one-block-per-cycle MD5 pipeline.
- Consumes the A/B/C/D state from the previous stage plus one 32-bit message word.
- Produces the rotated next state one clock later.
- Round function, additive constant and rotate amount are fixed per instance by parameters.

Parameters:
- ROUND, 0, step index 0..63; selects boolean function, and step 63 applies the final IV feed-forward.
- T_CONST, 32'h00000000, 32-bit MD5 additive constant T[ROUND].
- LROT_BITS, 7, left-rotate amount 0..31.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- message  input  32  message word M[g(ROUND)], already little-endian byte-swapped by the caller
- i_valid  input  1  upstream state valid
- i_a  input  32  state A in
- i_b  input  32  state B in
- i_c  input  32  state C in
- i_d  input  32  state D in
- o_valid  output  1  registered valid out
- o_a  output  32  state A out
- o_b  output  32  state B out
- o_c  output  32  state C out
- o_d  output  32  state D out

Behaviour:
- Reset (async, active-high): o_valid=0 and o_a/o_b/o_c/o_d=0, immediately and held while reset is high.
- Reset mid-stream discards any in-flight value; the first o_valid after release follows the first i_valid sampled after release.
- Latency is exactly 1 cycle. No backpressure: o_valid <= i_valid every clock.
- Data registers load only when i_valid=1; otherwise o_a..o_d hold their previous value.
- Round function, selected by ROUND at elaboration:
  - 0..15: F = (b & c) | (~b & d)
  - 16..31: G = (b & d) | (c & ~d)
  - 32..47: H = b ^ c ^ d
  - 48..63: I = c ^ (b | ~d)
- sum = i_a + func + T_CONST + message, all modulo 2^32 (carries discarded).
- rot = rotate-left(sum, LROT_BITS). LROT_BITS=0 passes sum unchanged.
- Next state (all additions modulo 2^32):
  - o_a <= i_d
  - o_b <= i_b + rot
  - o_c <= i_b
  - o_d <= i_c
- ROUND==63 only, single-block feed-forward: the step adds the MD5 IV to its results before registering.
  - o_a <= i_d + 32'h67452301
  - o_b <= i_b + rot + 32'hEFCDAB89
  - o_c <= i_b + 32'h98BADCFE
  - o_d <= i_c + 32'h10325476
- A ROUND outside 0..63 is a fatal elaboration error.
- Combinational path is a single adder tree plus one adder; no multicycle or state machine.

Test Plan:
- ROUND=0, T=d76aa478, s=7; i_a=67452301, i_b=efcdab89, i_c=98badcfe, i_d=10325476, message=00000080, i_valid=1.
  -> Next cycle o_valid=1, o_a=10325476, o_b=a5202774, o_c=efcdab89, o_d=98badcfe.
- ROUND=32, T=0, s=4; a=1, b=0, c=2, d=4, message=0.
  -> H=6, sum=7; o_b=00000070, o_a=4, o_c=0, o_d=2.
- ROUND=48, T=1, s=6; a=FFFFFFFF, b=0, c=0, d=FFFFFFFF, message=0.
  -> I=0, sum wraps to 0; o_b=0, o_a=FFFFFFFF, o_c=0, o_d=0.
- Rotate wrap: ROUND=16, s=31, T=0; sum forced to 00000001.
  -> rot=80000000.
- Valid handling: i_valid pulses 1,0,1 with distinct data.
  -> o_valid mirrors the pattern one cycle late; outputs hold during the 0 cycle.
- Reset asserted asynchronously mid-stream.
  -> All outputs 0 without waiting for a clock edge; the next valid after release propagates normally.
- Integration: 64 chained stages with ROUND 0..63 and standard T and shift tables, fed the padded empty-string block.
  -> After 64 cycles, byte-reversed A,B,C,D give d41d8cd98f00b204e9800998ecf8427e.

Source files
------------

// File: rtl/md5_step_stage.sv
// One registered MD5 step; chain 64 of these (ROUND 0..63) for a fully unrolled,
// one-block-per-cycle MD5 datapath. The last step also folds in the IV feed-forward.
module md5_step_stage #(
  parameter int          ROUND     = 0,
  parameter logic [31:0] T_CONST   = 32'h00000000,
  parameter int          LROT_BITS = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] message,
  input  logic        i_valid,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  output logic        o_valid,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d
);

  if (ROUND < 0 || ROUND > 63) begin : g_bad_round
    $fatal(1, "md5_step_stage: ROUND must be in 0..63");
  end
  if (LROT_BITS < 0 || LROT_BITS > 31) begin : g_bad_rot
    $fatal(1, "md5_step_stage: LROT_BITS must be in 0..31");
  end

  // Single-block feed-forward: only the final step adds the MD5 IV.
  localparam logic [31:0] FF_A = (ROUND == 63) ? 32'h67452301 : 32'h00000000;
  localparam logic [31:0] FF_B = (ROUND == 63) ? 32'hEFCDAB89 : 32'h00000000;
  localparam logic [31:0] FF_C = (ROUND == 63) ? 32'h98BADCFE : 32'h00000000;
  localparam logic [31:0] FF_D = (ROUND == 63) ? 32'h10325476 : 32'h00000000;

  logic [31:0] w_func;
  logic [31:0] w_sum;
  logic [31:0] w_rot;
  logic [31:0] w_next_a;
  logic [31:0] w_next_b;
  logic [31:0] w_next_c;
  logic [31:0] w_next_d;

  logic        r_valid;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_c;
  logic [31:0] r_d;

  for (genvar gi = 0; gi < 32; gi++) begin : g_func
    if (ROUND < 16) begin : g_f
      assign w_func[gi] = (i_b[gi] & i_c[gi]) | (~i_b[gi] & i_d[gi]);
    end else if (ROUND < 32) begin : g_g
      assign w_func[gi] = (i_b[gi] & i_d[gi]) | (i_c[gi] & ~i_d[gi]);
    end else if (ROUND < 48) begin : g_h
      assign w_func[gi] = i_b[gi] ^ i_c[gi] ^ i_d[gi];
    end else begin : g_i
      assign w_func[gi] = i_c[gi] ^ (i_b[gi] | ~i_d[gi]);
    end
  end

  assign w_sum = i_a + w_func + T_CONST + message;

  // A zero rotate is split out so the right shift never reaches 32.
  if (LROT_BITS == 0) begin : g_norot
    assign w_rot = w_sum;
  end else begin : g_rot
    assign w_rot = (w_sum << LROT_BITS) | (w_sum >> (32 - LROT_BITS));
  end

  assign w_next_a = i_d + FF_A;
  assign w_next_b = i_b + w_rot + FF_B;
  assign w_next_c = i_b + FF_C;
  assign w_next_d = i_c + FF_D;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_a     <= 32'h0;
      r_b     <= 32'h0;
      r_c     <= 32'h0;
      r_d     <= 32'h0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_a <= w_next_a;
        r_b <= w_next_b;
        r_c <= w_next_c;
        r_d <= w_next_d;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_c     = r_c;
  assign o_d     = r_d;

endmodule

// File: tb/tb_md5_step_stage.sv
// Bench for md5_step_stage: five single-step instances with different parameters
// share one stimulus bus, plus a 64-stage chain hashing the empty string.
module tb_md5_step_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_v;
  logic [31:0] in_a, in_b, in_c, in_d, in_m;

  always #5 clk = ~clk;

  localparam int          NDUT = 5;
  localparam int          P_ROUND [NDUT] = '{0, 32, 48, 16, 63};
  localparam logic [31:0] P_T     [NDUT] = '{32'hd76aa478, 32'h0, 32'h1, 32'h0, 32'h0};
  localparam int          P_S     [NDUT] = '{7, 4, 6, 31, 0};

  logic        sv_v [NDUT];
  logic [31:0] sv_a [NDUT];
  logic [31:0] sv_b [NDUT];
  logic [31:0] sv_c [NDUT];
  logic [31:0] sv_d [NDUT];

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    md5_step_stage #(.ROUND(P_ROUND[gi]), .T_CONST(P_T[gi]), .LROT_BITS(P_S[gi])) u_dut (
      .clk(clk), .reset(reset), .message(in_m), .i_valid(in_v),
      .i_a(in_a), .i_b(in_b), .i_c(in_c), .i_d(in_d),
      .o_valid(sv_v[gi]), .o_a(sv_a[gi]), .o_b(sv_b[gi]), .o_c(sv_c[gi]), .o_d(sv_d[gi])
    );
  end

  // Full 64-step chain with the standard MD5 tables.
  localparam logic [31:0] T_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  localparam int S_TAB [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  function automatic int msg_index(int i);
    if (i < 16)      return i;
    else if (i < 32) return (5 * i + 1) % 16;
    else if (i < 48) return (3 * i + 5) % 16;
    else             return (7 * i) % 16;
  endfunction

  logic        cin_v;
  logic [31:0] cin_a, cin_b, cin_c, cin_d;
  logic        ch_v [65];
  logic [31:0] ch_a [65];
  logic [31:0] ch_b [65];
  logic [31:0] ch_c [65];
  logic [31:0] ch_d [65];

  assign ch_v[0] = cin_v;
  assign ch_a[0] = cin_a;
  assign ch_b[0] = cin_b;
  assign ch_c[0] = cin_c;
  assign ch_d[0] = cin_d;

  for (genvar gi = 0; gi < 64; gi++) begin : g_chain
    // Padded empty message: only word 0 is nonzero (0x80 marker byte).
    localparam logic [31:0] MW = (msg_index(gi) == 0) ? 32'h00000080 : 32'h0;
    md5_step_stage #(.ROUND(gi), .T_CONST(T_TAB[gi]), .LROT_BITS(S_TAB[(gi / 16) * 4 + (gi % 4)])) u_stage (
      .clk(clk), .reset(reset), .message(MW), .i_valid(ch_v[gi]),
      .i_a(ch_a[gi]), .i_b(ch_b[gi]), .i_c(ch_c[gi]), .i_d(ch_d[gi]),
      .o_valid(ch_v[gi+1]), .o_a(ch_a[gi+1]), .o_b(ch_b[gi+1]), .o_c(ch_c[gi+1]), .o_d(ch_d[gi+1])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [127:0] dut_out(int sel);
    return {sv_a[sel], sv_b[sel], sv_c[sel], sv_d[sel]};
  endfunction

  typedef struct {
    string        name;
    int           sel;
    logic [127:0] exp;
  } sb_t;
  sb_t sbq[$];

  // Scoreboard: every valid output pops the oldest expectation.
  always @(negedge clk) begin
    if (!reset && sv_v[0]) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got o_valid=1 required 0 (no pending transaction)");
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check(e.name, dut_out(e.sel), e.exp);
      end
    end
  end

  typedef struct {
    string        name;
    int           sel;
    logic [31:0]  a, b, c, d, m;
    logic [127:0] exp;
  } vec_t;

  task automatic drive(input vec_t v, input logic push);
    in_v = 1'b1;
    in_a = v.a; in_b = v.b; in_c = v.c; in_d = v.d; in_m = v.m;
    if (push) sbq.push_back('{v.name, v.sel, v.exp});
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 5 && sbq.size() != 0; k++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %0d pending results required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [10];
    vec_t junk;
    int   lat;

    vecs[0] = '{"r0_spec",   0, 32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'h00000080,
                {32'h10325476, 32'ha5202774, 32'hefcdab89, 32'h98badcfe}};
    vecs[1] = '{"r0_f_selc", 0, 32'h0, 32'hffffffff, 32'h12345678, 32'h0, 32'h0,
                {32'h00000000, 32'hcf7d7873, 32'hffffffff, 32'h12345678}};
    vecs[2] = '{"r32_spec",  1, 32'h1, 32'h0, 32'h2, 32'h4, 32'h0,
                {32'h00000004, 32'h00000070, 32'h00000000, 32'h00000002}};
    vecs[3] = '{"r32_h_zero", 1, 32'h0, 32'hf0f0f0f0, 32'h0f0f0f0f, 32'hffffffff, 32'h10,
                {32'hffffffff, 32'hf0f0f1f0, 32'hf0f0f0f0, 32'h0f0f0f0f}};
    vecs[4] = '{"r48_wrap",  2, 32'hffffffff, 32'h0, 32'h0, 32'hffffffff, 32'h0,
                {32'hffffffff, 32'h00000000, 32'h00000000, 32'h00000000}};
    vecs[5] = '{"r48_i",     2, 32'h0, 32'h0, 32'h0000000f, 32'hfffffff0, 32'h0,
                {32'hfffffff0, 32'h00000040, 32'h00000000, 32'h0000000f}};
    vecs[6] = '{"r16_rot31", 3, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0,
                {32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000}};
    vecs[7] = '{"r16_rot31b", 3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2,
                {32'h00000000, 32'h00000001, 32'h00000000, 32'h00000000}};
    vecs[8] = '{"r16_g",     3, 32'h0, 32'hffff0000, 32'h0000ffff, 32'h00ff00ff, 32'h0,
                {32'h00ff00ff, 32'h007eff80, 32'hffff0000, 32'h0000ffff}};
    vecs[9] = '{"r63_ffwd",  4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                {32'h67452301, 32'hefcdab88, 32'h98badcfe, 32'h10325476}};
    junk    = '{"junk", 1, 32'hdeadbeef, 32'h13579bdf, 32'h2468ace0, 32'h0badf00d, 32'h55aa55aa, 128'h0};

    reset = 1'b1;
    in_v = 1'b0; in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_m = '0;
    cin_v = 1'b0; cin_a = '0; cin_b = '0; cin_c = '0; cin_d = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_r0", {95'h0, sv_v[0], dut_out(0)[31:0]} | {dut_out(0)[127:32], 32'h0}, 128'h0);
    check("reset_r63", {sv_v[4], dut_out(4)[126:0]} | {1'b0, dut_out(4)[127], 126'h0}, 128'h0);
    reset = 1'b0;

    // Table-driven single-step vectors, back to back.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i], 1'b1);
    end
    @(negedge clk);
    in_v = 1'b0;
    drain("table_drain");

    // Valid pattern 1,0,1: outputs hold through the idle cycle.
    @(negedge clk);
    drive(vecs[2], 1'b1);
    @(negedge clk);
    drive(junk, 1'b0);
    in_v = 1'b0;
    @(negedge clk);
    check("hold_valid", {127'h0, sv_v[1]}, 128'h0);
    check("hold_data", dut_out(1), vecs[2].exp);
    drive(vecs[3], 1'b1);
    @(negedge clk);
    in_v = 1'b0;
    drain("pulse_drain");

    // Asynchronous reset between clock edges discards the in-flight result.
    @(negedge clk);
    drive(vecs[0], 1'b0);
    @(posedge clk);
    #2;
    in_v = 1'b0;
    reset = 1'b1;
    sbq.delete();
    #1;
    check("async_rst_r0", {dut_out(0)[127:1], dut_out(0)[0] | sv_v[0]}, 128'h0);
    check("async_rst_r63", {dut_out(4)[127:1], dut_out(4)[0] | sv_v[4]}, 128'h0);
    @(negedge clk);
    check("rst_held", {dut_out(0)[127:1], dut_out(0)[0] | sv_v[0]}, 128'h0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {127'h0, sv_v[0]}, 128'h0);
    drive(vecs[4], 1'b1);
    @(negedge clk);
    in_v = 1'b0;
    drain("post_rst_drain");

    // Integration: empty-string MD5 through the 64-stage chain.
    @(negedge clk);
    cin_v = 1'b1;
    cin_a = 32'h67452301; cin_b = 32'hefcdab89; cin_c = 32'h98badcfe; cin_d = 32'h10325476;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      cin_v = 1'b0;
      if (ch_v[64]) begin
        lat = k;
        break;
      end
    end
    check("chain_latency", 128'(lat), 128'd64);
    check("md5_empty",
          {{<<8{ch_a[64]}}, {<<8{ch_b[64]}}, {<<8{ch_c[64]}}, {<<8{ch_d[64]}}},
          128'hd41d8cd98f00b204e9800998ecf8427e);
    @(negedge clk);
    check("chain_valid_drop", {127'h0, ch_v[64]}, 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
